// File: rtl/axi_pkt_arbiter8_pkg.sv
// Shared definitions for the 8-way packet-atomic AXI-stream arbiter.
//   ARB_RR / ARB_FIXED : arbitration mode values for the PRIO parameter.
//   NUM_CHAN           : number of input channels.
//   state_e            : arbiter FSM state encoding.
package axi_pkt_arbiter8_pkg;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;
   localparam int unsigned NUM_CHAN  = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } state_e;

endpackage

// File: rtl/rr_prio_enc8.sv
// Combinational 8-bit priority encoder, round-robin or fixed priority.
//   req_i    : request bitmap.
//   last_i   : previous winner; round-robin search starts at last_i + 1 (mod 8).
//   mode_i   : 0 = round-robin, 1 = fixed (lowest index wins).
//   winner_o : selected index (0 when no request).
//   any_o    : at least one request is set.
module rr_prio_enc8
   import axi_pkt_arbiter8_pkg::*;
(
   input  logic [7:0] req_i,
   input  logic [2:0] last_i,
   input  logic       mode_i,
   output logic [2:0] winner_o,
   output logic       any_o
);

   localparam logic MODE_FIXED = 1'(ARB_FIXED);

   assign any_o = |req_i;

   // Both searches scan from the lowest-priority candidate to the highest so the final
   // assignment that fires belongs to the highest-priority requester.
   always_comb begin
      logic [2:0] idx;
      winner_o = 3'd0;
      idx      = 3'd0;
      if (mode_i == MODE_FIXED) begin
         for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) winner_o = 3'(i);
         end
      end else begin
         for (int off = 8; off >= 1; off--) begin
            idx = 3'(32'(last_i) + off);  // wraps mod 8
            if (req_i[idx]) winner_o = idx;
         end
      end
   end

endmodule

// File: rtl/axi_pkt_arbiter8.sv
// Packet-atomic arbiter merging 8 AXI-stream inputs onto one output.
//   clk, reset_n       : clock, asynchronous active-low reset.
//   clear              : synchronous flush back to idle (abandons a packet in flight).
//   iN_t*              : input channel N stream (tready is driven by the arbiter).
//   o_t*               : merged output stream; combinational copy of the granted input.
//   grant              : index of the granted channel (0 while idle).
//   busy               : a packet is in progress.
// One idle cycle is spent arbitrating before every packet; once granted, a channel keeps
// the output until its tlast beat is accepted.
module axi_pkt_arbiter8
   import axi_pkt_arbiter8_pkg::*;
#(
   parameter int unsigned WIDTH       = 64,
   parameter logic [7:0]  ACTIVE_CHAN = 8'hFF,
   parameter int unsigned PRIO        = ARB_RR
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [WIDTH-1:0] i0_tdata,
   input  logic             i0_tlast,
   input  logic             i0_tvalid,
   output logic             i0_tready,
   input  logic [WIDTH-1:0] i1_tdata,
   input  logic             i1_tlast,
   input  logic             i1_tvalid,
   output logic             i1_tready,
   input  logic [WIDTH-1:0] i2_tdata,
   input  logic             i2_tlast,
   input  logic             i2_tvalid,
   output logic             i2_tready,
   input  logic [WIDTH-1:0] i3_tdata,
   input  logic             i3_tlast,
   input  logic             i3_tvalid,
   output logic             i3_tready,
   input  logic [WIDTH-1:0] i4_tdata,
   input  logic             i4_tlast,
   input  logic             i4_tvalid,
   output logic             i4_tready,
   input  logic [WIDTH-1:0] i5_tdata,
   input  logic             i5_tlast,
   input  logic             i5_tvalid,
   output logic             i5_tready,
   input  logic [WIDTH-1:0] i6_tdata,
   input  logic             i6_tlast,
   input  logic             i6_tvalid,
   output logic             i6_tready,
   input  logic [WIDTH-1:0] i7_tdata,
   input  logic             i7_tlast,
   input  logic             i7_tvalid,
   output logic             i7_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [2:0]       grant,
   output logic             busy
);

   logic [WIDTH-1:0] in_tdata [NUM_CHAN];
   logic [7:0]       in_tlast;
   logic [7:0]       in_tvalid;
   logic [7:0]       in_tready;
   logic [7:0]       req;
   logic [2:0]       winner;
   logic             any;

   state_e     state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [2:0] last_grant_q, last_grant_d;
   logic       busy_q, busy_d;

   assign in_tdata[0] = i0_tdata;
   assign in_tdata[1] = i1_tdata;
   assign in_tdata[2] = i2_tdata;
   assign in_tdata[3] = i3_tdata;
   assign in_tdata[4] = i4_tdata;
   assign in_tdata[5] = i5_tdata;
   assign in_tdata[6] = i6_tdata;
   assign in_tdata[7] = i7_tdata;
   assign in_tlast  = {i7_tlast, i6_tlast, i5_tlast, i4_tlast,
                       i3_tlast, i2_tlast, i1_tlast, i0_tlast};
   assign in_tvalid = {i7_tvalid, i6_tvalid, i5_tvalid, i4_tvalid,
                       i3_tvalid, i2_tvalid, i1_tvalid, i0_tvalid};
   assign {i7_tready, i6_tready, i5_tready, i4_tready,
           i3_tready, i2_tready, i1_tready, i0_tready} = in_tready;

   // Unconnected channels never raise a request.
   assign req = in_tvalid & ACTIVE_CHAN;

   rr_prio_enc8 u_enc (
      .req_i    (req),
      .last_i   (last_grant_q),
      .mode_i   (PRIO == ARB_FIXED),
      .winner_o (winner),
      .any_o    (any)
   );

   // Zero-latency data path from the granted input; everything is held at 0 while idle.
   always_comb begin
      o_tdata   = '0;
      o_tlast   = 1'b0;
      o_tvalid  = 1'b0;
      in_tready = '0;
      if (state_q == ST_PKT) begin
         case (grant_q)
            3'd0: o_tdata = in_tdata[0];
            3'd1: o_tdata = in_tdata[1];
            3'd2: o_tdata = in_tdata[2];
            3'd3: o_tdata = in_tdata[3];
            3'd4: o_tdata = in_tdata[4];
            3'd5: o_tdata = in_tdata[5];
            3'd6: o_tdata = in_tdata[6];
            3'd7: o_tdata = in_tdata[7];
         endcase
         o_tlast   = in_tlast[grant_q];
         o_tvalid  = in_tvalid[grant_q];
         in_tready = ACTIVE_CHAN & ({7'd0, o_tready} << grant_q);
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      busy_d       = busy_q;
      if (clear) begin
         state_d      = ST_IDLE;
         grant_d      = 3'd0;
         last_grant_d = 3'd7;
         busy_d       = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (any) begin
                  state_d = ST_PKT;
                  grant_d = winner;
                  busy_d  = 1'b1;
               end
            end
            ST_PKT: begin
               if (o_tvalid && o_tready && o_tlast) begin
                  state_d      = ST_IDLE;
                  last_grant_d = grant_q;
                  grant_d      = 3'd0;
                  busy_d       = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= 3'd0;
         last_grant_q <= 3'd7;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_axi_pkt_arbiter8.sv
// Testbench for axi_pkt_arbiter8. Three instances share one set of inputs:
//   dut 0: ACTIVE_CHAN=FF, round-robin; dut 1: ACTIVE_CHAN=F0, round-robin;
//   dut 2: ACTIVE_CHAN=FF, fixed priority.
module tb_axi_pkt_arbiter8;

   localparam int W = 32;

   logic         clk;
   logic         reset_n;
   logic         clear;
   logic         o_tready;
   logic [W-1:0] td [8];
   logic [7:0]   tl;
   logic [7:0]   tv;

   logic [W-1:0] d_tdata [3];
   logic         d_tlast [3];
   logic         d_tvalid [3];
   logic [7:0]   d_tready [3];
   logic [2:0]   d_grant [3];
   logic         d_busy [3];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: per instance, whether a packet is open, its channel, and the
   // channel that most recently completed a packet.
   bit m_busy [3];
   int m_cur  [3];
   int m_last [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      wire [W-1:0] od;
      wire         ol;
      wire         ov;
      wire [7:0]   rdy;
      wire [2:0]   g;
      wire         b;
      axi_pkt_arbiter8 #(
         .WIDTH       (W),
         .ACTIVE_CHAN ((k == 1) ? 8'hF0 : 8'hFF),
         .PRIO        ((k == 2) ? 1 : 0)
      ) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .clear     (clear),
         .i0_tdata  (td[0]), .i0_tlast (tl[0]), .i0_tvalid (tv[0]), .i0_tready (rdy[0]),
         .i1_tdata  (td[1]), .i1_tlast (tl[1]), .i1_tvalid (tv[1]), .i1_tready (rdy[1]),
         .i2_tdata  (td[2]), .i2_tlast (tl[2]), .i2_tvalid (tv[2]), .i2_tready (rdy[2]),
         .i3_tdata  (td[3]), .i3_tlast (tl[3]), .i3_tvalid (tv[3]), .i3_tready (rdy[3]),
         .i4_tdata  (td[4]), .i4_tlast (tl[4]), .i4_tvalid (tv[4]), .i4_tready (rdy[4]),
         .i5_tdata  (td[5]), .i5_tlast (tl[5]), .i5_tvalid (tv[5]), .i5_tready (rdy[5]),
         .i6_tdata  (td[6]), .i6_tlast (tl[6]), .i6_tvalid (tv[6]), .i6_tready (rdy[6]),
         .i7_tdata  (td[7]), .i7_tlast (tl[7]), .i7_tvalid (tv[7]), .i7_tready (rdy[7]),
         .o_tdata   (od),
         .o_tlast   (ol),
         .o_tvalid  (ov),
         .o_tready  (o_tready),
         .grant     (g),
         .busy      (b)
      );
      assign d_tdata[k]  = od;
      assign d_tlast[k]  = ol;
      assign d_tvalid[k] = ov;
      assign d_tready[k] = rdy;
      assign d_grant[k]  = g;
      assign d_busy[k]   = b;
   end

   function automatic logic [7:0] act_mask(input int k);
      return (k == 1) ? 8'hF0 : 8'hFF;
   endfunction

   // Arbitration straight from the rules: fixed = lowest requester, round-robin = first
   // requester found walking upward from the last winner.
   function automatic int pick(input int k);
      logic [7:0] r;
      r = tv & act_mask(k);
      if (k == 2) begin
         for (int i = 0; i < 8; i++) if (r[i]) return i;
      end else begin
         for (int off = 1; off <= 8; off++) if (r[(m_last[k] + off) % 8]) return (m_last[k] + off) % 8;
      end
      return -1;
   endfunction

   task automatic step_model();
      int w;
      for (int k = 0; k < 3; k++) begin
         if (!reset_n || clear) begin
            m_busy[k] = 1'b0;
            m_last[k] = 7;
         end else if (!m_busy[k]) begin
            w = pick(k);
            if (w >= 0) begin
               m_busy[k] = 1'b1;
               m_cur[k]  = w;
            end
         end else if (tv[m_cur[k]] && o_tready && tl[m_cur[k]]) begin
            m_busy[k] = 1'b0;
            m_last[k] = m_cur[k];
         end
      end
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [63:0] got, exp;
      logic [7:0]  er;
      int          c;
      for (int k = 0; k < 3; k++) begin
         got = {18'd0, d_tvalid[k], d_tlast[k], d_tdata[k], d_tready[k], d_grant[k], d_busy[k]};
         exp = '0;
         if (m_busy[k]) begin
            c     = m_cur[k];
            er    = 8'd0;
            er[c] = o_tready;
            exp   = {18'd0, tv[c], tl[c], td[c], er, 3'(c), 1'b1};
         end
         chk($sformatf("model_dut%0d", k), got, exp);
      end
   endtask

   // Advance one clock: model consumes the inputs that are stable across this edge.
   task automatic tick();
      step_model();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      tick();
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      clear    = 1'b0;
      tv       = '0;
      tl       = '0;
      o_tready = 1'b0;
      for (int i = 0; i < 8; i++) td[i] = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Leaves last_grant=1, then stops at the negedge where beat 2 of a ch4 packet is on o_t*.
   task automatic ch1_then_ch4_beat2();
      o_tready = 1'b1;
      tv[1] = 1'b1; tl[1] = 1'b1; td[1] = 32'h11;
      step();
      step();
      tv[1] = 1'b0; tl[1] = 1'b0;
      tv[4] = 1'b1; tl[4] = 1'b0; td[4] = 32'h400;
      step();
      for (int b = 0; b < 2; b++) begin
         td[4] = 32'h400 + 32'(b);
         step();
      end
      td[4] = 32'h402;
      @(negedge clk);
      chk("ch4_beat2", {60'd0, d_tvalid[0], d_grant[0]}, {60'd0, 1'b1, 3'd4});
   endtask

   task automatic wait_first_grant(input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(negedge clk);
         if (d_busy[0]) begin
            chk(name, 64'(d_grant[0]), 64'd0);
            found = 1'b1;
         end else begin
            tick();
         end
      end
      chk({name, "_seen"}, 64'(found), 64'd1);
   endtask

   typedef struct {
      logic        v;
      logic        l;
      logic [31:0] d;
      logic        e_v;
      logic        e_l;
      logic [31:0] e_d;
      logic [7:0]  e_rdy;
      logic [2:0]  e_g;
      logic        e_b;
   } vec_t;

   vec_t         tbl [15];
   logic [31:0]  got3 [$];
   int           pk, cnt, idx3, b2, b5;
   bit           ch3_done, ch0_got, acc3, a2, a5;
   logic [31:0]  dat;

   initial begin
      // Table: three 4-beat ch2 packets, each preceded by its arbitration cycle.
      for (int p = 0; p < 3; p++) begin
         tbl[p*5] = '{1'b1, 1'b0, 32'(p * 16), 1'b0, 1'b0, 32'd0, 8'h00, 3'd0, 1'b0};
         for (int b = 0; b < 4; b++) begin
            dat = 32'(p * 16 + b);
            tbl[p*5+1+b] = '{1'b1, (b == 3), dat, 1'b1, (b == 3), dat, 8'h04, 3'd2, 1'b1};
         end
      end

      do_reset();

      // Outputs forced to zero while reset is held, regardless of inputs.
      reset_n = 1'b0; tv = '1; tl = '1; o_tready = 1'b1;
      for (int i = 0; i < 8; i++) td[i] = $urandom;
      #2;
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset_out%0d", k),
             {18'd0, d_tvalid[k], d_tlast[k], d_tdata[k], d_tready[k], d_grant[k], d_busy[k]}, 0);

      // Ch2-only back-to-back packets.
      do_reset();
      o_tready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tv[2] = tbl[i].v; tl[2] = tbl[i].l; td[2] = tbl[i].d;
         @(negedge clk);
         chk($sformatf("ch2_vec%0d", i),
             {18'd0, d_tvalid[0], d_tlast[0], d_tdata[0], d_tready[0], d_grant[0], d_busy[0]},
             {18'd0, tbl[i].e_v, tbl[i].e_l, tbl[i].e_d, tbl[i].e_rdy, tbl[i].e_g, tbl[i].e_b});
         tick();
      end

      // All eight channels valid with single-beat packets: strict rotation.
      do_reset();
      o_tready = 1'b1; tv = '1; tl = '1;
      for (int i = 0; i < 8; i++) td[i] = 32'(i);
      pk = 0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (d_busy[0]) begin
            chk("rr_grant", 64'(d_grant[0]), 64'(pk % 8));
            if (d_tvalid[0] && d_tlast[0]) pk++;
         end
         tick();
      end
      chk("rr_count", 64'(pk), 64'd16);

      // Inactive channel 1 is ignored even while valid.
      do_reset();
      o_tready = 1'b1; tv = 8'b0100_0010; tl = '1;
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         chk("act_ch1", {62'd0, d_tready[1][1], (d_grant[1] == 3'd1)}, 64'd0);
         if (d_tready[1][6]) cnt++;
         tick();
      end
      chk("act_ch6_pkts", 64'(cnt), 64'd50);

      // Ch3 10-beat packet under toggling backpressure, ch0 requesting mid-packet.
      do_reset();
      idx3 = 0; ch3_done = 1'b0; ch0_got = 1'b0;
      got3.delete();
      for (int c = 0; c < 60 && !ch0_got; c++) begin
         tv[3] = (idx3 < 10); tl[3] = (idx3 == 9); td[3] = 32'h300 + 32'(idx3);
         tv[0] = (c >= 4) && !ch0_got; tl[0] = 1'b1; td[0] = 32'hC0;
         o_tready = (c % 2 == 0);
         @(negedge clk);
         acc3 = d_tready[0][3] && tv[3];
         if (d_busy[0] && !ch3_done) begin
            chk("ch3_hold", 64'(d_grant[0]), 64'd3);
         end else if (d_busy[0]) begin
            chk("ch0_next", 64'(d_grant[0]), 64'd0);
            ch0_got = 1'b1;
         end
         if (acc3) begin
            got3.push_back(d_tdata[0]);
            if (tl[3]) ch3_done = 1'b1;
         end
         tick();
         if (acc3) idx3++;
      end
      chk("ch0_granted", 64'(ch0_got), 64'd1);
      chk("ch3_beats", 64'(got3.size()), 64'd10);
      for (int i = 0; i < 10; i++)
         if (i < got3.size()) chk("ch3_data", 64'(got3[i]), 64'(32'h300 + 32'(i)));

      // Fixed priority: ch2 always beats ch5.
      do_reset();
      o_tready = 1'b1; b2 = 0; b5 = 0; cnt = 0;
      for (int c = 0; c < 40; c++) begin
         tv[2] = 1'b1; tv[5] = 1'b1;
         tl[2] = (b2 == 1); tl[5] = (b5 == 1);
         td[2] = 32'h200 + 32'(b2); td[5] = 32'h500 + 32'(b5);
         @(negedge clk);
         a2 = d_tready[2][2];
         a5 = d_tready[2][5];
         if (d_busy[2]) chk("fix_grant", 64'(d_grant[2]), 64'd2);
         if (a2 && tl[2]) cnt++;
         tick();
         if (a2) b2 = 1 - b2;
         if (a5) b5 = 1 - b5;
      end
      chk("fix_pkts", 64'(cnt), 64'd13);

      // Asynchronous reset in the middle of a packet.
      do_reset();
      ch1_then_ch4_beat2();
      #1 reset_n = 1'b0;
      #1 chk("rst_async", {62'd0, d_tvalid[0], d_busy[0]}, 64'd0);
      tick();
      reset_n = 1'b1; tv = '1; tl = '1;
      wait_first_grant("rst_first_grant");

      // Synchronous clear in the middle of a packet.
      do_reset();
      ch1_then_ch4_beat2();
      clear = 1'b1;
      #1 chk("clr_hold", 64'(d_tvalid[0]), 64'd1);
      tick();
      clear = 1'b0; tv = '1; tl = '1;
      @(negedge clk);
      chk("clr_idle", {62'd0, d_tvalid[0], d_busy[0]}, 64'd0);
      tick();
      wait_first_grant("clr_first_grant");

      // Random traffic on all three instances against the reference model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         tv = 8'($urandom);
         tl = 8'($urandom) & 8'($urandom);
         for (int i = 0; i < 8; i++) td[i] = $urandom;
         o_tready = ($urandom_range(0, 3) != 0);
         clear    = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         model_check();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
